// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int ROW_IDX_W = 2;

    typedef enum logic [2:0] {
        SCAN,
        DB_PRESS,
        EMIT,
        WAIT_REL,
        DB_REL
    } state_t;

    // Result of a column decode: valid means exactly one line is pulled low.
    typedef struct packed {
        logic                 valid;
        logic [ROW_IDX_W-1:0] index;
    } onehot_t;

    // Locates the single low bit of an active-low column vector.
    function automatic onehot_t onehot_low_index(input logic [COLS-1:0] v);
        onehot_t res;
        int      lows;
        res  = '0;
        lows = 0;
        for (int i = 0; i < COLS; i++) begin
            if (!v[i]) begin
                lows++;
                res.index = ROW_IDX_W'(i);
            end
        end
        res.valid = (lows == 1);
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Pin-level bundle between the keypad scanner and the matrix / SPI consumer.
interface keypad_scan_debounce_if;
    import keypad_pkg::*;

    logic [COLS-1:0]          col;
    logic [ROWS-1:0]          row;
    logic [2*ROW_IDX_W-1:0]   key_code;
    logic                     term;
    logic                     key_down;

    // Scanner side: reads the columns, drives rows and the key report.
    modport master (
        input  col,
        output row,
        output key_code,
        output term,
        output key_down
    );

    // Matrix / consumer side.
    modport slave (
        output col,
        input  row,
        input  key_code,
        input  term,
        input  key_down
    );

endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous column lines; idles high.
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col,
    output logic [COLS-1:0] colq
);

    logic [COLS-1:0] meta;

    // Shift the raw pins through two stages; reset to the pulled-up level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make both stages sample the old values on the same edge, giving a true two-stage pipeline.
        if (rst) begin
            meta <= '1;
            colq <= '1;
        end else begin
            meta <= col;
            colq <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debounce and a one-cycle key strobe.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 50_000,
    parameter int DEBOUNCE_TICKS = 500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    keypad_scan_debounce_if.master  bus
);

    localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [COLS-1:0]      colq;
    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ROW_IDX_W-1:0] row_idx;
    logic [ROW_IDX_W-1:0] cand_col;
    logic [3:0]           key_code;
    logic                 term;
    logic                 key_down;

    onehot_t              col_sel;
    logic                 cand_match;
    logic                 col_none;

    keypad_col_sync u_col_sync (
        .clk  (clk),
        .rst  (rst),
        .col  (bus.col),
        .colq (colq)
    );

    // Decode the synchronized columns for the FSM.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch can be inferred.
        col_sel    = onehot_low_index(colq);
        cand_match = (colq == ~(4'b0001 << cand_col));
        col_none   = &colq;
    end

    // Scan / debounce FSM with the shared dwell counter and registered outputs.
    // The key report is loaded on the edge into EMIT, so term is high exactly
    // for the single cycle that EMIT is the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            cnt      <= '0;
            row_idx  <= '0;
            cand_col <= '0;
            key_code <= '0;
            term     <= 1'b0;
            key_down <= 1'b0;
        end else begin
            term <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (col_sel.valid) begin
                            cand_col <= col_sel.index;
                            state    <= DB_PRESS;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DB_PRESS: begin
                    if (!cand_match) begin
                        cnt     <= '0;
                        row_idx <= row_idx + 1'b1;
                        state   <= SCAN;
                    end else if (cnt == DB_LAST) begin
                        cnt      <= '0;
                        key_code <= {row_idx, cand_col};
                        term     <= 1'b1;
                        key_down <= 1'b1;
                        state    <= EMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    cnt   <= '0;
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    cnt <= '0;
                    if (col_none) begin
                        state <= DB_REL;
                    end
                end
                DB_REL: begin
                    if (!col_none) begin
                        cnt   <= '0;
                        state <= WAIT_REL;
                    end else if (cnt == DB_LAST) begin
                        cnt      <= '0;
                        key_down <= 1'b0;
                        row_idx  <= row_idx + 1'b1;
                        state    <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SCAN;
                end
            endcase
        end
    end

    assign bus.row      = ~(4'b0001 << row_idx);
    assign bus.key_code = key_code;
    assign bus.term     = term;
    assign bus.key_down = key_down;

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Drives the 4x4 key matrix one row at a time and samples the columns. It debounces both press and release and reports each accepted key as a 4-bit code plus a single-cycle strobe. It sits directly upstream of the SPI interface and feeds that block's key_code and term inputs. The SPI side then buffers and transfers the key. Runs on the 50 MHz system clock (20 ns).

## Interface
- SCAN_TICKS, 50_000: clock cycles each row is driven (1 ms); must be >= 4.
- DEBOUNCE_TICKS, 500_000: clock cycles a press or release must stay stable (10 ms); must be >= 2.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- col  input  4  matrix column lines, pulled up externally, active-low, asynchronous.
- row  output  4  matrix row drive, one-hot active-low; all other rows driven high.
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}; connects to SPI key_code.
- term  output  1  one-cycle strobe, key_code newly valid; connects to SPI term.
- key_down  output  1  high from the accept cycle until release debounce completes.

## Operation
- col passes through a 2-flop synchronizer per bit; all decisions use the synchronized value colq.
- "single(c)": exactly one bit of colq is low, at index c. "none": colq == 4'b1111.
- row_idx is a 2-bit register. row = ~(4'b0001 << row_idx). It wraps 3 -> 0.
- One shared counter, width $clog2(max(SCAN_TICKS, DEBOUNCE_TICKS)). It is cleared on every state change.
- States:
  - SCAN:
    - Counter runs 0..SCAN_TICKS-1. Only the final dwell cycle is evaluated.
    - On that cycle, if single(c): latch cand_col = c, go to DB_PRESS, row_idx held.
    - Otherwise (none, or multiple lows = ghost/invalid): row_idx++ and stay in SCAN.
  - DB_PRESS:
    - If colq != the pattern single(cand_col) on any cycle: row_idx++, go to SCAN.
    - After DEBOUNCE_TICKS consecutive matching cycles: go to EMIT.
  - EMIT (1 cycle):
    - key_code <= {row_idx, cand_col}, term = 1, key_down <= 1.
    - Go to WAIT_REL.
  - WAIT_REL: stay while any colq bit is low; on none go to DB_REL.
  - DB_REL:
    - Any colq bit low: back to WAIT_REL.
    - After DEBOUNCE_TICKS consecutive none cycles: key_down <= 0, row_idx++, go to SCAN.
- Extra keys pressed while one key is held are ignored. No second term is issued until a full release debounce.
- key_code holds its value indefinitely between strobes. It is never cleared except by rst.
- There is no back-pressure: term is fire-and-forget. The SPI buffer owns overflow and busy handling.

## Timing
- Reset values:
  - row = 4'b1110 (row_idx 0)
  - key_code = 4'h0, term = 0, key_down = 0
  - state SCAN, counter 0, synchronizer flops 1.
- rst is sampled on a clk rising edge and overrides everything, including mid-debounce and EMIT. A term pulse in progress is not re-issued.
- Row dwell is exactly SCAN_TICKS cycles. Synchronizer latency is 2 cycles, so the evaluation sample reflects the pins as they were at least SCAN_TICKS-3 cycles after the row change.
- Press latency: term rises DEBOUNCE_TICKS+1 cycles after the SCAN evaluation cycle that detected single(c), provided the input stays clean.
- term is high for exactly 1 cycle; key_code changes on that same edge. key_down rises with term.
- After release, key_down falls DEBOUNCE_TICKS cycles after the first none cycle in DB_REL. The next row is driven on that same edge.
- Counter terminal compare uses TICKS-1; no overflow is possible.

## Structure
- keypad_pkg holds:
  - the state enum (SCAN, DB_PRESS, EMIT, WAIT_REL, DB_REL)
  - constants ROWS = 4, COLS = 4, ROW_IDX_W = 2
  - a function onehot_low_index returning {valid, index}, where valid means exactly one bit is low.
- One sub-module: keypad_col_sync, a 4-bit 2-flop synchronizer with sync reset to 1s.
- The FSM, counter and output registers live in the top.

## Test plan
Run with SCAN_TICKS=4, DEBOUNCE_TICKS=8.
1. Reset, then idle with col=4'b1111:
   - row = 1110 for 4 cycles, then 1101, 1011, 0111, 1110.
   - term stays 0 and key_code stays 0.
2. Hold col=4'b1101 whenever row=1011 (row 2, col 1):
   - exactly one term pulse with key_code=4'b1001, key_down=1.
   - row frozen at 1011 until the key is released.
3. Press bounce: col toggles 1101/1111 every 3 cycles during DB_PRESS → no term; scanning resumes with row=0111.
4. col=4'b1100 (two keys, same row) → no term; row keeps rotating.
5. After test 2, release with 4 cycles of bounce, then a clean high:
   - no second term.
   - key_down falls 8 cycles after the last low sample, and row becomes 0111.
6. Assert rst for 1 cycle at DB_PRESS count 5 → next cycle row=1110, key_down=0, term=0, key_code=0.
